// File: rtl/sa_array_skewed.sv
// Output-stationary systolic array (X columns by Y rows of MAC cells).
// Operands arrive aligned; internal skew registers stagger them per row and
// column. A small FSM sequences each tile: COMPUTE accepts K beats, FLUSH
// lets the wavefront reach the far corner, DRAIN streams one column per beat.
module sa_array_skewed #(
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int IA_W   = 8,
    parameter int IB_W   = 8,
    parameter int OC_W   = 32,
    parameter int K_W    = 16,
    parameter int SIGNED = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [K_W-1:0]    i_k,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [Y*IA_W-1:0] i_a_arr,
    input  logic [X*IB_W-1:0] i_b_arr,
    output logic              o_c_valid,
    input  logic              i_c_ready,
    output logic [Y*OC_W-1:0] o_c_arr,
    output logic              o_busy,
    output logic              o_done
);
    localparam int P_W  = IA_W + IB_W;
    localparam int FL_W = $clog2(X + Y + 1);
    localparam int DR_W = $clog2(X + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FLUSH   = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    // Full-precision product, sign- or zero-extended to the accumulator width.
    function automatic logic [OC_W-1:0] mac_prod(input logic [IA_W-1:0] a, input logic [IB_W-1:0] b);
        logic signed [P_W-1:0] ps;
        logic        [P_W-1:0] pu;
        ps = P_W'($signed(a)) * P_W'($signed(b));
        pu = P_W'(a) * P_W'(b);
        if (SIGNED != 0) begin
            mac_prod = OC_W'(ps);
        end else begin
            mac_prod = OC_W'(pu);
        end
    endfunction

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d, kcnt_q, kcnt_d;
    logic [FL_W-1:0]   fl_q, fl_d;
    logic [DR_W-1:0]   dr_q, dr_d;
    logic              in_ready_q, in_ready_d, c_valid_q, c_valid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              clear_s, accept_s, shift_s;

    logic [IA_W-1:0]   a_sk_s [Y];
    logic              v_sk_s [Y];
    logic [IB_W-1:0]   b_sk_s [X];

    logic [IA_W-1:0]   a_pe_q [Y][X], a_pe_d [Y][X];
    logic [IB_W-1:0]   b_pe_q [Y][X], b_pe_d [Y][X];
    logic              v_pe_q [Y][X], v_pe_d [Y][X];
    logic [OC_W-1:0]   acc_q  [Y][X], acc_d  [Y][X];
    logic [OC_W-1:0]   acc_nx_s [Y][X];

    assign accept_s = i_in_valid & in_ready_q;
    assign shift_s  = c_valid_q & i_c_ready;

    // Row skew: row j delays its A operand and the beat-valid bit by j cycles.
    for (genvar gj = 0; gj < Y; gj++) begin : g_a_skew
        if (gj == 0) begin : g_direct
            assign a_sk_s[gj] = i_a_arr[gj*IA_W +: IA_W];
            assign v_sk_s[gj] = accept_s;
        end else begin : g_regs
            logic [IA_W-1:0] sr_q [gj], sr_d [gj];
            logic [gj-1:0]   vsr_q, vsr_d;
            // Shift the row's operand and valid one stage per cycle.
            always_comb begin
                sr_d[0]  = i_a_arr[gj*IA_W +: IA_W];
                vsr_d[0] = accept_s;
                for (int s = 1; s < gj; s++) begin
                    sr_d[s]  = sr_q[s-1];
                    vsr_d[s] = vsr_q[s-1];
                end
            end
            // Row skew stage registers.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sr_q  <= '{default: '0};
                    vsr_q <= '0;
                end else begin
                    sr_q  <= sr_d;
                    vsr_q <= vsr_d;
                end
            end
            assign a_sk_s[gj] = sr_q[gj-1];
            assign v_sk_s[gj] = vsr_q[gj-1];
        end
    end

    // Column skew: column i delays its B operand by i cycles.
    for (genvar gi = 0; gi < X; gi++) begin : g_b_skew
        if (gi == 0) begin : g_direct
            assign b_sk_s[gi] = i_b_arr[gi*IB_W +: IB_W];
        end else begin : g_regs
            logic [IB_W-1:0] sr_q [gi], sr_d [gi];
            // Shift the column's operand one stage per cycle.
            always_comb begin
                sr_d[0] = i_b_arr[gi*IB_W +: IB_W];
                for (int s = 1; s < gi; s++) begin
                    sr_d[s] = sr_q[s-1];
                end
            end
            // Column skew stage registers.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sr_q <= '{default: '0};
                end else begin
                    sr_q <= sr_d;
                end
            end
            assign b_sk_s[gi] = sr_q[gi-1];
        end
    end

    // Drain shift source: each accumulator takes its right neighbour, last column takes zero.
    for (genvar gj = 0; gj < Y; gj++) begin : g_nx_row
        for (genvar gi = 0; gi < X; gi++) begin : g_nx_col
            if (gi < X - 1) begin : g_mid
                assign acc_nx_s[gj][gi] = acc_q[gj][gi+1];
            end else begin : g_end
                assign acc_nx_s[gj][gi] = '0;
            end
        end
        assign o_c_arr[gj*OC_W +: OC_W] = acc_q[gj][0];
    end

    // Operand propagation (A right, B down) and accumulator update.
    always_comb begin
        for (int j = 0; j < Y; j++) begin
            a_pe_d[j][0] = a_sk_s[j];
            v_pe_d[j][0] = v_sk_s[j];
            for (int i = 1; i < X; i++) begin
                a_pe_d[j][i] = a_pe_q[j][i-1];
                v_pe_d[j][i] = v_pe_q[j][i-1];
            end
        end
        for (int i = 0; i < X; i++) begin
            b_pe_d[0][i] = b_sk_s[i];
            for (int j = 1; j < Y; j++) begin
                b_pe_d[j][i] = b_pe_q[j-1][i];
            end
        end
        for (int j = 0; j < Y; j++) begin
            for (int i = 0; i < X; i++) begin
                if (clear_s) begin
                    acc_d[j][i] = '0;
                end else if (shift_s) begin
                    acc_d[j][i] = acc_nx_s[j][i];
                end else if (v_pe_q[j][i]) begin
                    acc_d[j][i] = acc_q[j][i] + mac_prod(a_pe_q[j][i], b_pe_q[j][i]);
                end else begin
                    acc_d[j][i] = acc_q[j][i];
                end
            end
        end
    end

    // PE operand, valid and accumulator registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_pe_q <= '{default: '0};
            b_pe_q <= '{default: '0};
            v_pe_q <= '{default: 1'b0};
            acc_q  <= '{default: '0};
        end else begin
            a_pe_q <= a_pe_d;
            b_pe_q <= b_pe_d;
            v_pe_q <= v_pe_d;
            acc_q  <= acc_d;
        end
    end

    // Tile sequencing: next state, counters, and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        kcnt_d  = kcnt_q;
        fl_d    = fl_q;
        dr_d    = dr_q;
        done_d  = 1'b0;
        clear_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    clear_s = 1'b1;
                    k_d     = i_k;
                    kcnt_d  = K_W'(0);
                    dr_d    = DR_W'(0);
                    if (i_k == K_W'(0)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_COMPUTE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPUTE: begin
                if (accept_s) begin
                    kcnt_d = kcnt_q + K_W'(1);
                    if ((kcnt_q + K_W'(1)) == k_q) begin
                        state_d = S_FLUSH;
                        fl_d    = FL_W'(X + Y - 2);
                    end else begin
                        state_d = S_COMPUTE;
                    end
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_FLUSH: begin
                if (fl_q == FL_W'(0)) begin
                    state_d = S_DRAIN;
                    dr_d    = DR_W'(0);
                end else begin
                    fl_d = fl_q - FL_W'(1);
                end
            end
            S_DRAIN: begin
                if (shift_s) begin
                    if (dr_q == DR_W'(X - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dr_d = dr_q + DR_W'(1);
                    end
                end else begin
                    dr_d = dr_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_COMPUTE);
        c_valid_d  = (state_d == S_DRAIN);
        busy_d     = (state_d != S_IDLE);
    end

    // FSM state, counters and registered handshake/status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            k_q        <= K_W'(0);
            kcnt_q     <= K_W'(0);
            fl_q       <= FL_W'(0);
            dr_q       <= DR_W'(0);
            in_ready_q <= 1'b0;
            c_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            kcnt_q     <= kcnt_d;
            fl_q       <= fl_d;
            dr_q       <= dr_d;
            in_ready_q <= in_ready_d;
            c_valid_q  <= c_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_in_ready = in_ready_q;
    assign o_c_valid  = c_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_sa_array_skewed.sv
// Bench for sa_array_skewed: a signed and an unsigned instance share stimulus;
// a table of tiles is driven, expected beats are queued from a reference model
// and popped as result handshakes occur.
module tb_sa_array_skewed;
    localparam int X = 4;
    localparam int Y = 4;

    logic         clk = 1'b0;
    logic         rst, start, in_valid, c_ready;
    logic [15:0]  k_in;
    logic [31:0]  a_arr, b_arr;
    logic         in_ready_s, c_valid_s, busy_s, done_s;
    logic         in_ready_u, c_valid_u, busy_u, done_u;
    logic [127:0] c_arr_s, c_arr_u;

    always #5 clk = ~clk;

    sa_array_skewed #(.X(X), .Y(Y), .IA_W(8), .IB_W(8), .OC_W(32), .K_W(16), .SIGNED(1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_k(k_in), .i_in_valid(in_valid),
        .o_in_ready(in_ready_s), .i_a_arr(a_arr), .i_b_arr(b_arr), .o_c_valid(c_valid_s),
        .i_c_ready(c_ready), .o_c_arr(c_arr_s), .o_busy(busy_s), .o_done(done_s));

    sa_array_skewed #(.X(X), .Y(Y), .IA_W(8), .IB_W(8), .OC_W(32), .K_W(16), .SIGNED(0)) dut_u (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_k(k_in), .i_in_valid(in_valid),
        .o_in_ready(in_ready_u), .i_a_arr(a_arr), .i_b_arr(b_arr), .o_c_valid(c_valid_u),
        .i_c_ready(c_ready), .o_c_arr(c_arr_u), .o_busy(busy_u), .o_done(done_u));

    typedef struct {
        int          k;
        logic [7:0]  a [4][4];   // [beat][row]
        logic [7:0]  b [4][4];   // [beat][column]
        bit          gaps;
        int          stall;
        bit          start_in_drain;
        logic [31:0] exp_s00;    // signed: beat 0 lane 0
        logic [31:0] exp_s33;    // signed: beat 3 lane 3
        logic [31:0] exp_u00;    // unsigned: beat 0 lane 0
    } vec_t;

    typedef struct packed {
        logic [127:0] s;
        logic [127:0] u;
    } beat_t;

    vec_t  vt [7];
    beat_t sb_q [$];
    int    errs = 0;
    int    checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_tile(input int v);
        int          bi, cyc, n, hs, stall_left, sa, sb, ua, ub;
        bit          tog;
        logic [31:0] ms [4][4];
        logic [31:0] mu [4][4];
        logic [127:0] snap;
        beat_t       e;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                ms[j][i] = 32'd0;
                mu[j][i] = 32'd0;
            end
        end
        snap  = '0;
        start = 1'b1;
        k_in  = 16'(vt[v].k);
        @(negedge clk);
        start = 1'b0;
        k_in  = 16'($urandom_range(1, 9));
        chk("busy_after_start", 128'(busy_s), 128'(1));
        chk("done_low_after_start", 128'(done_s), 128'(0));
        bi  = 0;
        cyc = 0;
        tog = 1'b1;
        if (vt[v].k > 0) chk("in_ready_compute", 128'(in_ready_s), 128'(1));
        while (bi < vt[v].k && cyc < 200) begin
            in_valid = vt[v].gaps ? tog : 1'b1;
            tog = ~tog;
            if (in_valid) begin
                for (int j = 0; j < 4; j++) a_arr[j*8 +: 8] = vt[v].a[bi][j];
                for (int i = 0; i < 4; i++) b_arr[i*8 +: 8] = vt[v].b[bi][i];
            end else begin
                a_arr = $urandom();
                b_arr = $urandom();
            end
            if (in_valid && in_ready_s) begin
                for (int j = 0; j < 4; j++) begin
                    for (int i = 0; i < 4; i++) begin
                        sa = $signed(vt[v].a[bi][j]);
                        sb = $signed(vt[v].b[bi][i]);
                        ua = vt[v].a[bi][j];
                        ub = vt[v].b[bi][i];
                        ms[j][i] = ms[j][i] + 32'(sa * sb);
                        mu[j][i] = mu[j][i] + 32'(ua * ub);
                    end
                end
                bi++;
            end
            @(negedge clk);
            cyc++;
        end
        if (bi != vt[v].k) chk("feed_timeout", 128'(bi), 128'(vt[v].k));
        // Operand beats outside COMPUTE must be ignored.
        in_valid = 1'b1;
        a_arr    = $urandom();
        b_arr    = $urandom();
        if (vt[v].k > 0) begin
            chk("in_ready_drop", 128'(in_ready_s), 128'(0));
            n = 1;
            while (!c_valid_s && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("first_valid_latency", 128'(n), 128'(X + Y));
        end else begin
            chk("k0_drain_immediate", 128'(c_valid_s), 128'(1));
        end
        for (int c = 0; c < X; c++) begin
            for (int j = 0; j < Y; j++) begin
                e.s[j*32 +: 32] = ms[j][c];
                e.u[j*32 +: 32] = mu[j][c];
            end
            sb_q.push_back(e);
        end
        hs = 0;
        cyc = 0;
        stall_left = vt[v].stall;
        while (hs < X && cyc < 100) begin
            if (vt[v].start_in_drain && hs == 1) begin
                start = 1'b1;
                k_in  = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (stall_left > 0) begin
                c_ready = 1'b0;
                if (stall_left == vt[v].stall) begin
                    snap = c_arr_s;
                end else begin
                    chk("stall_hold_data", c_arr_s, snap);
                    chk("stall_hold_valid", 128'(c_valid_s), 128'(1));
                end
                stall_left--;
            end else begin
                c_ready = 1'b1;
                if (c_valid_s) begin
                    e = sb_q.pop_front();
                    chk("beat_signed", c_arr_s, e.s);
                    chk("beat_unsigned", c_arr_u, e.u);
                    chk("valid_unsigned", 128'(c_valid_u), 128'(1));
                    if (hs == 0) chk("table_s00", 128'(c_arr_s[31:0]), 128'(vt[v].exp_s00));
                    if (hs == 0) chk("table_u00", 128'(c_arr_u[31:0]), 128'(vt[v].exp_u00));
                    if (hs == 3) chk("table_s33", 128'(c_arr_s[127:96]), 128'(vt[v].exp_s33));
                    hs++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (hs != X) chk("drain_timeout", 128'(hs), 128'(X));
        chk("done_pulse_s", 128'(done_s), 128'(1));
        chk("done_pulse_u", 128'(done_u), 128'(1));
        chk("valid_off_after_drain", 128'(c_valid_s), 128'(0));
        chk("idle_after_drain", 128'(busy_s), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < 7; v++) begin
            vt[v].k = 0; vt[v].gaps = 1'b0; vt[v].stall = 0; vt[v].start_in_drain = 1'b0;
            vt[v].exp_s00 = 32'd0; vt[v].exp_s33 = 32'd0; vt[v].exp_u00 = 32'd0;
            for (int t = 0; t < 4; t++) begin
                for (int j = 0; j < 4; j++) begin
                    vt[v].a[t][j] = 8'd0;
                    vt[v].b[t][j] = 8'd0;
                end
            end
        end
        // 0: K=1, a=1s, b=[1,2,3,4] -> beat n lanes = n+1
        vt[0].k = 1;
        for (int j = 0; j < 4; j++) begin vt[0].a[0][j] = 8'd1; vt[0].b[0][j] = 8'(j + 1); end
        vt[0].exp_s00 = 32'd1; vt[0].exp_s33 = 32'd4; vt[0].exp_u00 = 32'd1;
        // 1: K=4 identity A, B beat k = [k+1..k+4] -> lane j beat n = j+n+1
        vt[1].k = 4;
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 4; j++) begin
                vt[1].a[t][j] = (j == t) ? 8'd1 : 8'd0;
                vt[1].b[t][j] = 8'(t + j + 1);
            end
        end
        vt[1].exp_s00 = 32'd1; vt[1].exp_s33 = 32'd7; vt[1].exp_u00 = 32'd1;
        // 2: K=3, all -128 -> 49152 (0x80 unsigned is 128, same result)
        vt[2].k = 3;
        for (int t = 0; t < 3; t++) begin
            for (int j = 0; j < 4; j++) begin vt[2].a[t][j] = 8'h80; vt[2].b[t][j] = 8'h80; end
        end
        vt[2].exp_s00 = 32'd49152; vt[2].exp_s33 = 32'd49152; vt[2].exp_u00 = 32'd49152;
        // 3: K=2, all 0xFF -> unsigned 130050, signed 2
        vt[3].k = 2;
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < 4; j++) begin vt[3].a[t][j] = 8'hFF; vt[3].b[t][j] = 8'hFF; end
        end
        vt[3].exp_s00 = 32'd2; vt[3].exp_s33 = 32'd2; vt[3].exp_u00 = 32'd130050;
        // 4: vector 1 with input gaps and a 3-cycle drain stall
        vt[4] = vt[1];
        vt[4].gaps = 1'b1; vt[4].stall = 3;
        // 5: K=0 -> zero beats; start pulsed during drain is ignored
        vt[5].start_in_drain = 1'b1;
        // 6: post-reset K=1, a=[2,3,4,5], b=1s -> lane j = j+2
        vt[6].k = 1;
        for (int j = 0; j < 4; j++) begin vt[6].a[0][j] = 8'(j + 2); vt[6].b[0][j] = 8'd1; end
        vt[6].exp_s00 = 32'd2; vt[6].exp_s33 = 32'd5; vt[6].exp_u00 = 32'd2;

        rst = 1'b1; start = 1'b0; k_in = 16'd0; in_valid = 1'b0; c_ready = 1'b0;
        a_arr = 32'd0; b_arr = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'({in_ready_s, in_ready_u}), 128'(0));
        chk("rst_c_valid", 128'({c_valid_s, c_valid_u}), 128'(0));
        chk("rst_busy_done", 128'({busy_s, busy_u, done_s, done_u}), 128'(0));
        chk("rst_c_arr", c_arr_s | c_arr_u, 128'(0));
        rst = 1'b0;
        in_valid = 1'b1;
        a_arr = $urandom();
        b_arr = $urandom();
        @(negedge clk);
        chk("idle_ignores_in_valid", 128'(in_ready_s), 128'(0));

        // Tiles run back to back: each new start lands on the previous done cycle.
        for (int v = 0; v < 6; v++) begin
            run_tile(v);
        end
        @(negedge clk);
        chk("start_in_drain_ignored", 128'(busy_s), 128'(0));
        chk("done_single_pulse", 128'(done_s), 128'(0));

        // Reset in the middle of COMPUTE after 2 of 4 beats.
        start = 1'b1; k_in = 16'd4;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_valid = 1'b1;
            a_arr = 32'h0101_0101;
            b_arr = 32'h0403_0201;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 128'({in_ready_s, in_ready_u}), 128'(0));
        chk("midrst_c_valid", 128'({c_valid_s, c_valid_u}), 128'(0));
        chk("midrst_busy_done", 128'({busy_s, busy_u, done_s, done_u}), 128'(0));
        chk("midrst_c_arr", c_arr_s | c_arr_u, 128'(0));
        run_tile(6);
        @(negedge clk);
        chk("final_done_low", 128'(done_s), 128'(0));
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sa_array_skewed.md
Name: sa_array_skewed

Overview:
- Self-contained, parametrised output-stationary systolic array, X columns by Y rows, of simple multiply-accumulate cells.
- Adds what the previous array generation lacked:
  - internal input skew registers, so the host presents A and B operands aligned, not pre-skewed;
  - a reduction-length counter;
  - a flush/drain state machine;
  - a valid/ready handshake on both the input and the result streams.
- Sits between the operand feeders and the output buffer. Runs one tile of K reduction steps per start command.

Parameters:
X, 4, number of PE columns (B operands, result beats per drain)
Y, 4, number of PE rows (A operands, result lanes)
IA_W, 8, activation operand width
IB_W, 8, weight operand width
OC_W, 32, accumulator/result width; must be >= IA_W+IB_W
K_W, 16, width of the reduction-length field
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  start tile; sampled only in IDLE
i_k  in  K_W  reduction length, latched on accepted i_start
i_in_valid  in  1  operand beat valid
o_in_ready  out  1  operand beat accepted when valid&&ready
i_a_arr  in  Y*IA_W  aligned activation operands, element j feeds row j
i_b_arr  in  X*IB_W  aligned weight operands, element i feeds column i
o_c_valid  out  1  result beat valid
i_c_ready  in  1  result beat consumed when valid&&ready
o_c_arr  out  Y*OC_W  result beat, lane j = row j
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high (i_rst).
- Reset values:
  - all accumulators, skew registers and PE valid flops = 0;
  - FSM = IDLE;
  - o_in_ready, o_c_valid, o_busy, o_done = 0;
  - o_c_arr = 0.
- Reset mid-operation: abandons the tile; no partial results are emitted.
- Skew:
  - row j's A operand passes through j register stages;
  - column i's B operand passes through i register stages;
  - a valid bit travels with A.
- Propagation: A moves right one PE per cycle; B moves down one PE per cycle. A beat accepted at cycle t reaches PE(j,i) at cycle t+1+i+j.
- PE accumulate rule:
  - when the valid bit is set, acc += a*b;
  - the product is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to OC_W;
  - the sum wraps modulo 2^OC_W.
- Beats with i_in_valid low are gaps. No token is inserted, and PEs with valid=0 hold their accumulator.
- FSM states:
  - IDLE:
    - o_in_ready=0.
    - i_start → clear all accumulators and latch K=i_k.
    - If K=0, go to DRAIN; otherwise go to COMPUTE with the beat counter at 0.
  - COMPUTE:
    - o_in_ready=1; the counter increments per accepted beat.
    - The accept that makes the count equal K → FLUSH.
    - o_in_ready drops the cycle after that accept.
  - FLUSH:
    - o_in_ready=0; lasts exactly X+Y-1 cycles, counted by a down-counter.
    - Then → DRAIN.
  - DRAIN:
    - o_c_valid=1 and o_c_arr[j] = acc[j][0].
    - On each handshake the accumulators shift left: acc[j][i] ← acc[j][i+1], acc[j][X-1] ← 0.
    - Beat n therefore carries column n.
    - After X handshakes → IDLE with o_done=1 for that one cycle.
    - If i_c_ready is low, o_c_valid and o_c_arr hold stable.
- Output timing:
  - o_in_ready and o_c_valid are decoded from registered state only; they are not combinational from inputs.
  - The first o_c_valid is asserted X+Y-1 cycles after the K-th accept, plus one cycle for the state transition.
- Boundary cases:
  - i_start outside IDLE is ignored.
  - i_in_valid outside COMPUTE is ignored.
  - A new i_start on the o_done cycle is honoured, because the FSM is already in IDLE.
  - i_k is ignored unless i_start is accepted.
- No pipeline-stall input exists; backpressure occurs only via i_in_valid gaps and i_c_ready.

Test Plan:
- X=Y=4, K=1, a=[1,1,1,1], b=[1,2,3,4] → 4 result beats; beat n has every lane = n+1; o_done pulses once after beat 4.
- K=4, A rows = identity over 4 beats, B beat k = [k+1,k+2,k+3,k+4] → lane j beat n = j+n+1, matching the golden matrix product.
- SIGNED=1, K=3, every a=-128, b=-128 → every result = 49152. SIGNED=0 with a=b=255, K=2 → 130050.
- K=4 with i_in_valid toggling 1,0,1,0… and i_c_ready low for 3 cycles at drain start → same results as the gap-free run; o_c_arr holds stable while stalled.
- K=0 start → X beats of all-zero results, then o_done. i_start pulsed during DRAIN → ignored.
- i_rst asserted mid-COMPUTE after 2 of 4 beats → next cycle FSM IDLE and all outputs 0. A fresh K=1 tile then produces correct results with no residue.
